// File: rtl/fifo_ptr_pkg.sv
// fifo_ptr_pkg: shared pointer helpers (Gray/binary conversion, pointer width) for the async FIFO.
// Rev 1.0
`default_nettype none

package fifo_ptr_pkg;

  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int MAX_PTR_W           = 32;

  typedef logic [MAX_PTR_W-1:0] ptr_word_t;

  function automatic int PTR_W(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic ptr_word_t width_mask(input int w);
    if (w >= MAX_PTR_W) begin
      return '1;
    end
    return (ptr_word_t'(1) << w) - ptr_word_t'(1);
  endfunction

  // Callers zero-extend a w-bit value into ptr_word_t and truncate the result back to w bits.
  function automatic ptr_word_t bin2gray(input ptr_word_t bin, input int w);
    ptr_word_t b;
    b = bin & width_mask(w);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t gray, input int w);
    ptr_word_t b;
    b = gray & width_mask(w);
    for (int s = 1; s < MAX_PTR_W; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ptr_sync.sv
// ptr_sync: PW-bit x SYNC_STAGES flop chain for carrying a Gray pointer across clock domains.
// Rev 1.0
`default_nettype none

module ptr_sync
  import fifo_ptr_pkg::*;
#(
  parameter int PW          = 5,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PW-1:0] d_i,
  output logic [PW-1:0] q_o,
  output logic [PW-1:0] q_next_o
);

  logic [PW-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o      = sync_q[SYNC_STAGES-1];
  // Value the last stage loads at the next edge, so consumers can register flags in step with it.
  assign q_next_o = sync_q[SYNC_STAGES-2];

endmodule

`default_nettype wire

// File: rtl/async_fifo_rd_ctrl.sv
// async_fifo_rd_ctrl: read-side pointer, empty/count/underflow flags; RD_ALMOST_EMPTY_EN adds almost_empty.
// Rev 1.0
`default_nettype none

module async_fifo_rd_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int AE_THRESH   = 2,
  localparam int PW         = PTR_W(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PW-1:0]         wr_gray_async,
  input  logic                  rd_req,
  output logic                  rd_ack,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [PW-1:0]         rd_gray,
  output logic                  empty,
  output logic [PW-1:0]         rd_count,
  output logic                  underflow
`ifdef RD_ALMOST_EMPTY_EN
  ,
  output logic                  almost_empty
`endif
);

  logic [PW-1:0] sync_last;
  logic [PW-1:0] sync_next;
  logic [PW-1:0] wr_bin_next;
  logic [PW-1:0] rd_bin_q,   rd_bin_d;
  logic [PW-1:0] rd_gray_q,  rd_gray_d;
  logic [PW-1:0] rd_count_q, rd_count_d;
  logic          empty_q,    empty_d;
  logic          underflow_q, underflow_d;

  ptr_sync #(
    .PW          (PW),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_i      (wr_gray_async),
    .q_o      (sync_last),
    .q_next_o (sync_next)
  );

  assign rd_ack = rd_req & ~empty_q;

  // Flags are computed from next-state pointers so they never lag the registered pointers.
  always_comb begin
    rd_bin_d    = rd_bin_q + PW'(rd_ack);
    rd_gray_d   = PW'(bin2gray(ptr_word_t'(rd_bin_d), PW));
    wr_bin_next = PW'(gray2bin(ptr_word_t'(sync_next), PW));
    empty_d     = (rd_gray_d == sync_next);
    rd_count_d  = wr_bin_next - rd_bin_d;
    underflow_d = rd_req & empty_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_bin_q    <= '0;
      rd_gray_q   <= '0;
      rd_count_q  <= '0;
      empty_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      rd_bin_q    <= rd_bin_d;
      rd_gray_q   <= rd_gray_d;
      rd_count_q  <= rd_count_d;
      empty_q     <= empty_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef RD_ALMOST_EMPTY_EN
  localparam logic [PW-1:0] AE_LEVEL = PW'(AE_THRESH);

  logic almost_empty_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      almost_empty_q <= 1'b1;
    end else begin
      almost_empty_q <= (rd_count_d <= AE_LEVEL);
    end
  end

  assign almost_empty = almost_empty_q;
`else
  localparam int unused_ae_thresh = AE_THRESH;
`endif

  assign rd_addr   = rd_bin_q[ADDR_WIDTH-1:0];
  assign rd_gray   = rd_gray_q;
  assign empty     = empty_q;
  assign rd_count  = rd_count_q;
  assign underflow = underflow_q;

  a_empty_consistent: assert property (
    @(posedge clk) disable iff (!rst_n) empty_q == (rd_gray_q == sync_last)
  );

endmodule

`default_nettype wire
